// File: rtl/instr_fetch.sv
// instr_fetch: macro-instruction fetch stage feeding the microprogram
// address generator. Owns PC and IR, reads one instruction byte from program
// memory over a req/ack handshake, and turns the opcode nibble into a
// microprogram entry address announced with a one-cycle entry_valid pulse.
// Optional feature: define INSTR_FETCH_PREFETCH_EN to add a one-entry,
// address-tagged prefetch buffer that is filled after every decode.
module instr_fetch #(
  parameter logic [7:0] ENTRY_BASE  = 8'h10,
  parameter int         ENTRY_SHIFT = 2,
  parameter int         TIMEOUT     = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       fetch_req,
  input  logic       pc_ld,
  input  logic [7:0] pc_in,
  output logic [7:0] mem_addr,
  output logic       mem_rd,
  input  logic [7:0] mem_data,
  input  logic       mem_ack,
  output logic [7:0] ir,
  output logic [7:0] pc_out,
  output logic [7:0] entry_addr,
  output logic       entry_valid,
  output logic       busy,
  output logic       fault
);

`ifdef INSTR_FETCH_PREFETCH_EN
  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_DECODE, S_FAULT, S_PREFETCH
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE, S_REQ, S_DECODE, S_FAULT
  } state_t;
`endif

  // Last counter value before a missing ack is declared a timeout.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] ir_q, ir_d;
  logic [7:0] entry_addr_q, entry_addr_d;
  logic       entry_valid_q, entry_valid_d;
  logic       mem_rd_q, mem_rd_d;
  logic [7:0] mem_addr_q, mem_addr_d;
  logic       fault_q, fault_d;
  logic [7:0] cnt_q, cnt_d;
  // A fetch request that arrived together with a jump (or during prefetch).
  logic       pending_q, pending_d;

  logic [7:0] opcode_ext;
  logic [7:0] entry_calc;
  logic       pbuf_hit;

`ifdef INSTR_FETCH_PREFETCH_EN
  logic [7:0] pbuf_q, pbuf_d;
  logic [7:0] ptag_q, ptag_d;
  logic       pvalid_q, pvalid_d;
  assign pbuf_hit = pvalid_q && (ptag_q == pc_q);
`else
  assign pbuf_hit = 1'b0;
`endif

  // Entry address: base plus opcode times microwords-per-opcode, mod 256.
  assign opcode_ext = {4'h0, ir_q[7:4]};
  assign entry_calc = ENTRY_BASE + (opcode_ext << ENTRY_SHIFT);

  // Next-state and next-register values for every FSM state.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is
    // inferred on paths that do not assign it.
    state_d       = state_q;
    pc_d          = pc_q;
    ir_d          = ir_q;
    entry_addr_d  = entry_addr_q;
    entry_valid_d = 1'b0;
    mem_rd_d      = mem_rd_q;
    mem_addr_d    = mem_addr_q;
    fault_d       = fault_q;
    cnt_d         = cnt_q;
    pending_d     = pending_q;
`ifdef INSTR_FETCH_PREFETCH_EN
    pbuf_d        = pbuf_q;
    ptag_d        = ptag_q;
    pvalid_d      = pvalid_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (pc_ld) begin
          // Jump wins; a simultaneous request starts from the new PC.
          pc_d      = pc_in;
          pending_d = pending_q | fetch_req;
`ifdef INSTR_FETCH_PREFETCH_EN
          pvalid_d  = 1'b0;
`endif
        end else if (fetch_req || pending_q) begin
          pending_d = 1'b0;
          if (pbuf_hit) begin
`ifdef INSTR_FETCH_PREFETCH_EN
            ir_d     = pbuf_q;
            pvalid_d = 1'b0;
`endif
            pc_d    = pc_q + 8'd1;
            state_d = S_DECODE;
          end else begin
            mem_rd_d   = 1'b1;
            mem_addr_d = pc_q;
            cnt_d      = 8'd0;
            state_d    = S_REQ;
          end
        end
      end

      S_REQ: begin
        if (mem_ack) begin
          ir_d     = mem_data;
          pc_d     = pc_q + 8'd1;
          mem_rd_d = 1'b0;
          state_d  = S_DECODE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          mem_rd_d = 1'b0;
          fault_d  = 1'b1;
          state_d  = S_FAULT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      S_DECODE: begin
        entry_addr_d  = entry_calc;
        entry_valid_d = 1'b1;
`ifdef INSTR_FETCH_PREFETCH_EN
        mem_rd_d      = 1'b1;
        mem_addr_d    = pc_q;
        cnt_d         = 8'd0;
        state_d       = S_PREFETCH;
`else
        state_d       = S_IDLE;
`endif
      end

      S_FAULT: begin
        if (pc_ld) begin
          pc_d    = pc_in;
          fault_d = 1'b0;
          state_d = S_IDLE;
`ifdef INSTR_FETCH_PREFETCH_EN
          pvalid_d = 1'b0;
`endif
        end
      end

`ifdef INSTR_FETCH_PREFETCH_EN
      S_PREFETCH: begin
        if (pc_ld) begin
          mem_rd_d  = 1'b0;
          pc_d      = pc_in;
          pvalid_d  = 1'b0;
          pending_d = pending_q | fetch_req;
          state_d   = S_IDLE;
        end else begin
          if (fetch_req) pending_d = 1'b1;
          if (mem_ack) begin
            pbuf_d   = mem_data;
            ptag_d   = mem_addr_q;
            pvalid_d = 1'b1;
            mem_rd_d = 1'b0;
            state_d  = S_IDLE;
          end else if (cnt_q == TIMEOUT_LAST) begin
            // A failed prefetch is harmless: no fault, just no buffer.
            mem_rd_d = 1'b0;
            pvalid_d = 1'b0;
            state_d  = S_IDLE;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
`endif

      default: state_d = S_IDLE;
    endcase
  end

  // State register; frozen while run is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else if (run) begin
      // NOTE: clocked state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      state_q <= state_d;
    end
  end

  // Datapath registers; frozen while run is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q          <= 8'h00;
      ir_q          <= 8'h00;
      entry_addr_q  <= 8'h00;
      entry_valid_q <= 1'b0;
      mem_rd_q      <= 1'b0;
      mem_addr_q    <= 8'h00;
      fault_q       <= 1'b0;
      cnt_q         <= 8'd0;
      pending_q     <= 1'b0;
`ifdef INSTR_FETCH_PREFETCH_EN
      // NOTE: the buffer byte and tag are reset along with pvalid; it is one
      // register, not a memory array, so the reset costs nothing.
      pbuf_q        <= 8'h00;
      ptag_q        <= 8'h00;
      pvalid_q      <= 1'b0;
`endif
    end else if (run) begin
      pc_q          <= pc_d;
      ir_q          <= ir_d;
      entry_addr_q  <= entry_addr_d;
      entry_valid_q <= entry_valid_d;
      mem_rd_q      <= mem_rd_d;
      mem_addr_q    <= mem_addr_d;
      fault_q       <= fault_d;
      cnt_q         <= cnt_d;
      pending_q     <= pending_d;
`ifdef INSTR_FETCH_PREFETCH_EN
      pbuf_q        <= pbuf_d;
      ptag_q        <= ptag_d;
      pvalid_q      <= pvalid_d;
`endif
    end
  end

  assign mem_addr    = mem_addr_q;
  assign mem_rd      = mem_rd_q;
  assign ir          = ir_q;
  assign pc_out      = pc_q;
  assign entry_addr  = entry_addr_q;
  assign entry_valid = entry_valid_q;
  assign fault       = fault_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed bench for instr_fetch. Stimulus pushes the expected
// decode result into a scoreboard queue; a monitor pops and compares each time
// the DUT pulses entry_valid. A memory responder answers mem_rd requests.
module tb_instr_fetch;

  logic       clk = 1'b0;
  logic       rst;
  logic       run;
  logic       fetch_req;
  logic       pc_ld;
  logic [7:0] pc_in;
  logic [7:0] mem_addr;
  logic       mem_rd;
  logic [7:0] mem_data;
  logic       mem_ack;
  logic [7:0] ir;
  logic [7:0] pc_out;
  logic [7:0] entry_addr;
  logic       entry_valid;
  logic       busy;
  logic       fault;

  typedef struct packed {
    logic [7:0] entry;
    logic [7:0] ir;
    logic [7:0] pc;
  } exp_t;

  exp_t       sb[$];
  int         total = 0;
  int         bad   = 0;
  logic [7:0] mem [256];
  logic       ack_en;

  instr_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .fetch_req   (fetch_req),
    .pc_ld       (pc_ld),
    .pc_in       (pc_in),
    .mem_addr    (mem_addr),
    .mem_rd      (mem_rd),
    .mem_data    (mem_data),
    .mem_ack     (mem_ack),
    .ir          (ir),
    .pc_out      (pc_out),
    .entry_addr  (entry_addr),
    .entry_valid (entry_valid),
    .busy        (busy),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 50) begin
      tick();
      n++;
    end
    check("idle_wait_busy", {31'd0, busy}, 32'd0);
  endtask

  // Memory responder: ack on the negedge after mem_rd is seen, if enabled.
  always @(negedge clk) begin
    if (mem_rd && ack_en) begin
      mem_ack  = 1'b1;
      mem_data = mem[mem_addr];
    end else begin
      mem_ack  = 1'b0;
      mem_data = 8'h00;
    end
  end

  // Monitor: every entry_valid pulse must match the next scoreboard entry.
  always @(negedge clk) begin
    if (rst && entry_valid) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_entry_valid: got 1 expected 0 at %0t", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_entry_addr", {24'd0, entry_addr}, {24'd0, e.entry});
        check("sb_ir",         {24'd0, ir},         {24'd0, e.ir});
        check("sb_pc",         {24'd0, pc_out},     {24'd0, e.pc});
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[8'h00] = 8'h35;
    mem[8'hFF] = 8'hF0;
    mem[8'h20] = 8'hA7;
    mem[8'h05] = 8'h42;

    rst = 1'b0; run = 1'b1; fetch_req = 1'b0; pc_ld = 1'b0; pc_in = 8'h00;
    mem_ack = 1'b0; mem_data = 8'h00; ack_en = 1'b1;

    // Reset state.
    #12;
    check("rst_pc",          {24'd0, pc_out},     32'h00);
    check("rst_ir",          {24'd0, ir},         32'h00);
    check("rst_entry_addr",  {24'd0, entry_addr}, 32'h00);
    check("rst_mem_rd",      {31'd0, mem_rd},     32'd0);
    check("rst_entry_valid", {31'd0, entry_valid}, 32'd0);
    check("rst_busy",        {31'd0, busy},       32'd0);
    check("rst_fault",       {31'd0, fault},      32'd0);
    tick();
    rst = 1'b1;

    // Basic fetch of 8'h35 at address 0, with latency check.
    fetch_req = 1'b1;
    sb.push_back('{entry: 8'h1C, ir: 8'h35, pc: 8'h01});
    tick();
    fetch_req = 1'b0;
    check("f1_mem_rd",   {31'd0, mem_rd}, 32'd1);
    check("f1_mem_addr", {24'd0, mem_addr}, 32'h00);
    check("f1_busy",     {31'd0, busy}, 32'd1);
    tick();
    check("f1_ir",       {24'd0, ir}, 32'h35);
    check("f1_pc",       {24'd0, pc_out}, 32'h01);
    check("f1_mem_rd_drop", {31'd0, mem_rd}, 32'd0);
    check("f1_ev_early", {31'd0, entry_valid}, 32'd0);
    tick();
    check("f1_ev_latency", {31'd0, entry_valid}, 32'd1);
    tick();
    check("f1_ev_one_cycle", {31'd0, entry_valid}, 32'd0);

    // Jump to FF, fetch F0, PC wraps to 00.
    pc_ld = 1'b1; pc_in = 8'hFF;
    tick();
    pc_ld = 1'b0;
    check("jmp_pc", {24'd0, pc_out}, 32'hFF);
    fetch_req = 1'b1;
    sb.push_back('{entry: 8'h4C, ir: 8'hF0, pc: 8'h00});
    tick();
    fetch_req = 1'b0;
    check("jmp_mem_addr", {24'd0, mem_addr}, 32'hFF);
    wait_idle();
    check("jmp_pc_wrap", {24'd0, pc_out}, 32'h00);

    // Simultaneous pc_ld and fetch_req: fetch uses the new PC.
    pc_ld = 1'b1; pc_in = 8'h20; fetch_req = 1'b1;
    tick();
    pc_ld = 1'b0; fetch_req = 1'b0;
    check("both_pc", {24'd0, pc_out}, 32'h20);
    check("both_no_rd_yet", {31'd0, mem_rd}, 32'd0);
    sb.push_back('{entry: 8'h38, ir: 8'hA7, pc: 8'h21});
    tick();
    check("both_mem_rd", {31'd0, mem_rd}, 32'd1);
    check("both_mem_addr", {24'd0, mem_addr}, 32'h20);
    wait_idle();

    // Timeout: 15 REQ cycles without ack.
    ack_en = 1'b0;
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    check("to_rd_before", {31'd0, mem_rd}, 32'd1);
    check("to_fault_before", {31'd0, fault}, 32'd0);
    tick();
    check("to_rd_drop", {31'd0, mem_rd}, 32'd0);
    check("to_fault", {31'd0, fault}, 32'd1);
    check("to_busy", {31'd0, busy}, 32'd1);
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    tick();
    check("to_req_ignored_rd", {31'd0, mem_rd}, 32'd0);
    check("to_req_ignored_fault", {31'd0, fault}, 32'd1);
    pc_ld = 1'b1; pc_in = 8'h05;
    tick();
    pc_ld = 1'b0;
    check("to_clear_fault", {31'd0, fault}, 32'd0);
    check("to_clear_busy", {31'd0, busy}, 32'd0);
    check("to_clear_pc", {24'd0, pc_out}, 32'h05);

    // Freeze during REQ: counter must not advance while run is low.
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    run = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("frz_rd", {31'd0, mem_rd}, 32'd1);
    check("frz_busy", {31'd0, busy}, 32'd1);
    check("frz_addr", {24'd0, mem_addr}, 32'h05);
    check("frz_pc", {24'd0, pc_out}, 32'h05);
    run = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check("frz_no_fault", {31'd0, fault}, 32'd0);
    check("frz_rd_after", {31'd0, mem_rd}, 32'd1);
    sb.push_back('{entry: 8'h20, ir: 8'h42, pc: 8'h06});
    ack_en = 1'b1;
    wait_idle();

    // Asynchronous reset in the middle of REQ.
    ack_en = 1'b0;
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    tick();
    check("ar_rd_before", {31'd0, mem_rd}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check("ar_rd", {31'd0, mem_rd}, 32'd0);
    check("ar_pc", {24'd0, pc_out}, 32'h00);
    check("ar_ir", {24'd0, ir}, 32'h00);
    check("ar_busy", {31'd0, busy}, 32'd0);
    tick();
    rst = 1'b1;
    ack_en = 1'b1;

    // Normal operation resumes after reset.
    fetch_req = 1'b1;
    sb.push_back('{entry: 8'h1C, ir: 8'h35, pc: 8'h01});
    tick();
    fetch_req = 1'b0;
    wait_idle();
    tick();
    tick();

    check("sb_drained", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
